// File: rtl/term_fb_sequencer.sv
// term_fb_sequencer: sole write master of the text framebuffer (init clear, chars, CR/LF, row clear, cursor blink)
module term_fb_sequencer #(
   parameter int         COLS        = 80,
   parameter int         ROWS        = 30,
   parameter int         ADDR_W      = 12,
   parameter int         BLINK_DIV   = 8388608,
   parameter logic [7:0] CURSOR_CHAR = 8'h5F,
   parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [7:0]        fb_wdata,
   output logic [6:0]        cur_x,
   output logic [4:0]        cur_y,
   output logic              busy
);
   localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(COLS * ROWS - 1);
   typedef enum logic [2:0] {INIT, IDLE, WRITE, ERASE, CLEAR, BLINK} state_t;
   state_t            state;
   logic [BW-1:0]     blink_cnt;
   logic              blink_pend, phase, is_lf, tick;
   logic [6:0]        clr_cnt;
   logic [4:0]        next_y;
   logic [ADDR_W-1:0] cur_addr, next_row_addr;
   always_comb begin
      tick          = blink_cnt == BW'(BLINK_DIV - 1);
      cur_addr      = ADDR_W'(cur_y) * ADDR_W'(COLS) + ADDR_W'(cur_x);
      next_y        = cur_y == 5'(ROWS - 1) ? 5'd0 : cur_y + 5'd1;
      next_row_addr = ADDR_W'(next_y) * ADDR_W'(COLS);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= INIT;
         fb_we      <= 1'b0;
         fb_addr    <= '0;
         fb_wdata   <= BLANK_CHAR;
         in_ready   <= 1'b0;
         cur_x      <= '0;
         cur_y      <= '0;
         busy       <= 1'b1;
         blink_cnt  <= '0;
         blink_pend <= 1'b0;
         phase      <= 1'b0;
         is_lf      <= 1'b0;
         clr_cnt    <= '0;
      end else begin
         blink_cnt <= tick ? '0 : blink_cnt + BW'(1);
         if (tick) blink_pend <= 1'b1;
         case (state)
            INIT: begin
               fb_we    <= 1'b1;
               fb_wdata <= BLANK_CHAR;
               if (!fb_we) fb_addr <= '0;
               else if (fb_addr == LAST) begin
                  fb_we    <= 1'b0;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else fb_addr <= fb_addr + ADDR_W'(1);
            end
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  fb_we    <= 1'b1;
                  fb_addr  <= cur_addr;
                  is_lf    <= in_data == 8'h0A;
                  if (in_data == 8'h0D || in_data == 8'h0A) begin
                     fb_wdata <= BLANK_CHAR;
                     state    <= ERASE;
                  end else begin
                     fb_wdata <= in_data;
                     phase    <= 1'b0;
                     state    <= WRITE;
                  end
               end else if (blink_pend) begin
                  in_ready   <= 1'b0;
                  busy       <= 1'b1;
                  fb_we      <= 1'b1;
                  fb_addr    <= cur_addr;
                  fb_wdata   <= phase ? BLANK_CHAR : CURSOR_CHAR;
                  phase      <= !phase;
                  blink_pend <= tick;
                  state      <= BLINK;
               end
            end
            WRITE, ERASE: begin
               // a row advance leads straight into clearing the new row
               if (state == ERASE || cur_x == 7'(COLS - 1)) cur_x <= '0;
               else cur_x <= cur_x + 7'd1;
               if ((state == ERASE && is_lf) || (state == WRITE && cur_x == 7'(COLS - 1))) begin
                  cur_y    <= next_y;
                  fb_we    <= 1'b1;
                  fb_wdata <= BLANK_CHAR;
                  fb_addr  <= next_row_addr;
                  clr_cnt  <= '0;
                  state    <= CLEAR;
               end else begin
                  fb_we    <= 1'b0;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
            CLEAR: begin
               if (clr_cnt == 7'(COLS - 1)) begin
                  fb_we    <= 1'b0;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else begin
                  fb_addr <= fb_addr + ADDR_W'(1);
                  clr_cnt <= clr_cnt + 7'd1;
               end
            end
            BLINK: begin
               fb_we    <= 1'b0;
               in_ready <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= INIT;
         endcase
      end
   end
endmodule

// File: tb/tb_term_fb_sequencer.sv
// tb_term_fb_sequencer: randomized bench with a transaction-level screen/cursor model
module tb_term_fb_sequencer;
   logic        clk = 0, reset = 1, in_valid = 0;
   logic [7:0]  in_data = 0;
   logic        in_ready, fb_we, busy;
   logic [11:0] fb_addr;
   logic [7:0]  fb_wdata;
   logic [6:0]  cur_x;
   logic [4:0]  cur_y;
   term_fb_sequencer #(.BLINK_DIV(16)) dut (.clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .cur_x(cur_x), .cur_y(cur_y), .busy(busy));
   always #20 clk = ~clk;
   int n_cmp = 0, n_bad = 0;
   int cycle = 0, writes_seen = 0, bad_writes = 0, blinks_seen = 0;
   int mx = 0, my = 0;
   bit mphase = 0;
   logic [19:0] exp_q[$];
   logic        s_fb_we, s_in_ready, s_busy;
   logic [11:0] s_fb_addr;
   logic [7:0]  s_fb_wdata;
   logic [6:0]  s_cur_x;
   logic [4:0]  s_cur_y;
   // one clock: sample at negedge and account any write against the expected stream or a blink
   task automatic cyc();
      @(negedge clk);
      cycle++;
      s_fb_we = fb_we; s_fb_addr = fb_addr; s_fb_wdata = fb_wdata;
      s_in_ready = in_ready; s_busy = busy; s_cur_x = cur_x; s_cur_y = cur_y;
      if (fb_we) begin
         writes_seen++;
         if (exp_q.size() != 0) begin
            if (exp_q[0] != {fb_addr, fb_wdata}) bad_writes++;
            void'(exp_q.pop_front());
         end else begin
            if (fb_addr != 12'(my * 80 + mx) || fb_wdata != (mphase ? 8'h20 : 8'h5F)) bad_writes++;
            mphase = !mphase;
            blinks_seen++;
         end
      end
   endtask
   task automatic model_accept(input logic [7:0] c, output int el);
      int base;
      base = my * 80 + mx;
      el = 2;
      exp_q.push_back({12'(base), (c == 8'h0D || c == 8'h0A) ? 8'h20 : c});
      if (c == 8'h0D) mx = 0;
      else if (c == 8'h0A) begin mx = 0; my = (my + 1) % 30; el = 82; end
      else begin
         mphase = 0;
         if (mx == 79) begin mx = 0; my = (my + 1) % 30; el = 82; end
         else mx++;
      end
      if (el == 82) for (int i = 0; i < 80; i++) exp_q.push_back({12'(my * 80 + i), 8'h20});
   endtask
   task automatic push_init();
      exp_q.delete();
      for (int i = 0; i < 2400; i++) exp_q.push_back({12'(i), 8'h20});
   endtask
   task automatic send(input logic [7:0] c, output int lat, output int el, output logic we1,
                       output logic [11:0] a1, output logic [7:0] d1);
      int n;
      in_data = c; in_valid = 1;
      n = 0;
      while (!s_in_ready && n < 1000) begin cyc(); n++; end
      model_accept(c, el);
      cyc();
      in_valid = 0;
      we1 = s_fb_we; a1 = s_fb_addr; d1 = s_fb_wdata;
      lat = 1;
      while (!s_in_ready && lat < 1000) begin cyc(); lat++; end
   endtask
   function automatic logic [7:0] rand_print();
      return 8'($urandom_range(32, 126));
   endfunction
   task automatic test_reset();
      repeat (3) cyc();
      n_cmp++; if (s_fb_we !== 1'b0) begin n_bad++; $display("FAIL reset_fb_we: got %0b expected 0", s_fb_we); end
      n_cmp++; if (s_fb_addr !== 12'd0) begin n_bad++; $display("FAIL reset_fb_addr: got %0d expected 0", s_fb_addr); end
      n_cmp++; if (s_fb_wdata !== 8'h20) begin n_bad++; $display("FAIL reset_fb_wdata: got %h expected 20", s_fb_wdata); end
      n_cmp++; if (s_in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %0b expected 0", s_in_ready); end
      n_cmp++; if ({s_cur_x, s_cur_y} !== 12'd0) begin n_bad++; $display("FAIL reset_cursor: got (%0d,%0d) expected (0,0)", s_cur_x, s_cur_y); end
      n_cmp++; if (s_busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %0b expected 1", s_busy); end
   endtask
   task automatic test_init();
      int w0, b0, n;
      push_init();
      w0 = writes_seen; b0 = bad_writes;
      reset = 0;
      n = 0;
      while (n < 3000) begin cyc(); n++; if (s_in_ready) break; end
      n_cmp++; if (writes_seen - w0 != 2400) begin n_bad++; $display("FAIL init_count: got %0d expected 2400", writes_seen - w0); end
      n_cmp++; if (bad_writes != b0 || exp_q.size() != 0) begin n_bad++; $display("FAIL init_order: got %0d bad, %0d left expected 0,0", bad_writes - b0, exp_q.size()); end
      n_cmp++; if (s_busy !== 1'b0 || s_in_ready !== 1'b1) begin n_bad++; $display("FAIL init_idle: got busy=%0b ready=%0b expected 0,1", s_busy, s_in_ready); end
   endtask
   task automatic test_single();
      int lat, el; logic we1; logic [11:0] a1; logic [7:0] d1;
      send(8'h41, lat, el, we1, a1, d1);
      n_cmp++; if (we1 !== 1'b1 || a1 !== 12'd0 || d1 !== 8'h41) begin n_bad++; $display("FAIL single_write: got we=%0b addr=%0d data=%h expected 1,0,41", we1, a1, d1); end
      n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL single_ready_latency: got %0d expected 2", lat); end
      n_cmp++; if (s_cur_x !== 7'd1 || s_cur_y !== 5'd0) begin n_bad++; $display("FAIL single_cursor: got (%0d,%0d) expected (1,0)", s_cur_x, s_cur_y); end
   endtask
   task automatic test_row_wrap();
      int lat, el, b0; logic we1; logic [11:0] a1; logic [7:0] d1;
      b0 = bad_writes;
      send(8'h0D, lat, el, we1, a1, d1);
      for (int i = 0; i < 80; i++) send(rand_print(), lat, el, we1, a1, d1);
      n_cmp++; if (a1 !== 12'd79) begin n_bad++; $display("FAIL wrap_last_addr: got %0d expected 79", a1); end
      n_cmp++; if (lat != 82) begin n_bad++; $display("FAIL wrap_latency: got %0d expected 82", lat); end
      n_cmp++; if (s_cur_x !== 7'd0 || s_cur_y !== 5'd1) begin n_bad++; $display("FAIL wrap_cursor: got (%0d,%0d) expected (0,1)", s_cur_x, s_cur_y); end
      n_cmp++; if (bad_writes != b0 || exp_q.size() != 0) begin n_bad++; $display("FAIL wrap_stream: got %0d bad, %0d left expected 0,0", bad_writes - b0, exp_q.size()); end
   endtask
   task automatic test_lf_cr();
      int lat, el, b0; logic we1; logic [11:0] a1; logic [7:0] d1;
      b0 = bad_writes;
      repeat (28) send(8'h0A, lat, el, we1, a1, d1);
      repeat (5) send(rand_print(), lat, el, we1, a1, d1);
      send(8'h0A, lat, el, we1, a1, d1);
      n_cmp++; if (a1 !== 12'd2325 || d1 !== 8'h20) begin n_bad++; $display("FAIL lf_erase: got addr=%0d data=%h expected 2325,20", a1, d1); end
      n_cmp++; if (lat != 82) begin n_bad++; $display("FAIL lf_latency: got %0d expected 82", lat); end
      n_cmp++; if (s_cur_x !== 7'd0 || s_cur_y !== 5'd0) begin n_bad++; $display("FAIL lf_cursor: got (%0d,%0d) expected (0,0)", s_cur_x, s_cur_y); end
      repeat (3) send(8'h0A, lat, el, we1, a1, d1);
      repeat (5) send(rand_print(), lat, el, we1, a1, d1);
      send(8'h0D, lat, el, we1, a1, d1);
      n_cmp++; if (a1 !== 12'd245 || d1 !== 8'h20) begin n_bad++; $display("FAIL cr_erase: got addr=%0d data=%h expected 245,20", a1, d1); end
      n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL cr_latency: got %0d expected 2", lat); end
      n_cmp++; if (s_cur_x !== 7'd0 || s_cur_y !== 5'd3) begin n_bad++; $display("FAIL cr_cursor: got (%0d,%0d) expected (0,3)", s_cur_x, s_cur_y); end
      n_cmp++; if (bad_writes != b0 || exp_q.size() != 0) begin n_bad++; $display("FAIL lfcr_stream: got %0d bad, %0d left expected 0,0", bad_writes - b0, exp_q.size()); end
   endtask
   task automatic test_blink();
      int lat, el, nb, n, addr_bad;
      logic we1; logic [11:0] a1; logic [7:0] d1, c;
      int bc[4]; logic [11:0] ba[4]; logic [7:0] bd[4];
      repeat (28) send(8'h0A, lat, el, we1, a1, d1);
      repeat (2) send(rand_print(), lat, el, we1, a1, d1);
      n_cmp++; if (s_cur_x !== 7'd2 || s_cur_y !== 5'd1) begin n_bad++; $display("FAIL blink_start_cursor: got (%0d,%0d) expected (2,1)", s_cur_x, s_cur_y); end
      nb = 0; n = 0;
      while (nb < 4 && n < 200) begin
         cyc(); n++;
         if (s_fb_we) begin bc[nb] = cycle; ba[nb] = s_fb_addr; bd[nb] = s_fb_wdata; nb++; end
      end
      addr_bad = 0;
      for (int i = 0; i < nb; i++) if (ba[i] !== 12'd82) addr_bad++;
      n_cmp++; if (nb != 4 || addr_bad != 0) begin n_bad++; $display("FAIL blink_addr: got %0d blinks, %0d off-cursor expected 4,0", nb, addr_bad); end
      n_cmp++; if (bd[0] !== 8'h5F || bd[1] !== 8'h20 || bd[2] !== 8'h5F || bd[3] !== 8'h20) begin n_bad++; $display("FAIL blink_data: got %h %h %h %h expected 5f 20 5f 20", bd[0], bd[1], bd[2], bd[3]); end
      n_cmp++; if (bc[2] - bc[1] != 16 || bc[3] - bc[2] != 16) begin n_bad++; $display("FAIL blink_period: got %0d,%0d expected 16,16", bc[2] - bc[1], bc[3] - bc[2]); end
      // next tick lands 15 cycles after a serviced blink; hold a char while it is pending
      repeat (15) cyc();
      c = rand_print();
      send(c, lat, el, we1, a1, d1);
      n_cmp++; if (we1 !== 1'b1 || a1 !== 12'd82 || d1 !== c) begin n_bad++; $display("FAIL blink_char_first: got we=%0b addr=%0d data=%h expected 1,82,%h", we1, a1, d1, c); end
      n = 0;
      while (n < 20) begin cyc(); n++; if (s_fb_we) break; end
      n_cmp++; if (n != 1 || s_fb_addr !== 12'd83 || s_fb_wdata !== 8'h5F) begin n_bad++; $display("FAIL blink_after_char: got delay=%0d addr=%0d data=%h expected 1,83,5f", n, s_fb_addr, s_fb_wdata); end
   endtask
   task automatic test_random();
      int lat, el, b0, lat_bad, we_bad, r;
      logic we1; logic [11:0] a1; logic [7:0] d1, c;
      b0 = bad_writes; lat_bad = 0; we_bad = 0;
      for (int i = 0; i < 150; i++) begin
         repeat ($urandom_range(0, 20)) cyc();
         r = $urandom_range(0, 9);
         c = r == 0 ? 8'h0D : r == 1 ? 8'h0A : rand_print();
         send(c, lat, el, we1, a1, d1);
         if (lat != el) lat_bad++;
         if (!we1) we_bad++;
      end
      n_cmp++; if (lat_bad != 0 || we_bad != 0) begin n_bad++; $display("FAIL rand_latency: got %0d ready / %0d write latency errors expected 0", lat_bad, we_bad); end
      n_cmp++; if (bad_writes != b0 || exp_q.size() != 0) begin n_bad++; $display("FAIL rand_stream: got %0d bad, %0d left expected 0,0", bad_writes - b0, exp_q.size()); end
      n_cmp++; if (s_cur_x !== 7'(mx) || s_cur_y !== 5'(my)) begin n_bad++; $display("FAIL rand_cursor: got (%0d,%0d) expected (%0d,%0d)", s_cur_x, s_cur_y, mx, my); end
   endtask
   task automatic test_reset_mid_clear();
      int lat, el, w0, b0, n; logic we1; logic [11:0] a1; logic [7:0] d1;
      n = 0;
      while (my != 0 && n < 40) begin send(8'h0A, lat, el, we1, a1, d1); n++; end
      model_accept(8'h0A, el);
      in_data = 8'h0A; in_valid = 1;
      cyc();
      in_valid = 0;
      repeat (5) cyc();
      n_cmp++; if (s_fb_we !== 1'b1 || s_fb_addr !== 12'd84 || s_cur_y !== 5'd1) begin n_bad++; $display("FAIL midclear_state: got we=%0b addr=%0d y=%0d expected 1,84,1", s_fb_we, s_fb_addr, s_cur_y); end
      reset = 1;
      exp_q.delete();
      cyc();
      n_cmp++; if (s_fb_we !== 1'b0 || s_busy !== 1'b1 || s_in_ready !== 1'b0) begin n_bad++; $display("FAIL midclear_reset: got we=%0b busy=%0b ready=%0b expected 0,1,0", s_fb_we, s_busy, s_in_ready); end
      n_cmp++; if (s_cur_x !== 7'd0 || s_cur_y !== 5'd0) begin n_bad++; $display("FAIL midclear_cursor: got (%0d,%0d) expected (0,0)", s_cur_x, s_cur_y); end
      mx = 0; my = 0; mphase = 0;
      push_init();
      w0 = writes_seen; b0 = bad_writes;
      reset = 0;
      n = 0;
      while (n < 3000) begin cyc(); n++; if (s_in_ready) break; end
      n_cmp++; if (writes_seen - w0 != 2400 || bad_writes != b0 || exp_q.size() != 0) begin n_bad++; $display("FAIL reinit: got %0d writes, %0d bad, %0d left expected 2400,0,0", writes_seen - w0, bad_writes - b0, exp_q.size()); end
   endtask
   initial begin
      test_reset();
      test_init();
      test_single();
      test_row_wrap();
      test_lf_cr();
      test_blink();
      test_random();
      test_reset_mid_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
